// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences FETCH/DECODE/per-op states
// and Moore-decodes every datapath select, write enable and ALU code. Optional bne: MULTICYCLE_BNE_EN.
module multicycle_ctrl #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pcen,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic [STATE_W-1:0] state,
    output logic               bad_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } state_t;

    state_t cur_state;
    state_t nxt_state;
    state_t dec_state;

    logic       pcwrite;
    logic       branch;
    logic       taken;
    logic       op_ok;
    logic       funct_ok;
    logic [1:0] aluop;

    assign state = cur_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

`ifdef MULTICYCLE_BNE_EN
    // Remembers which branch flavour was decoded so BRANCH can pick the zero polarity.
    logic branch_ne;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_ne <= 1'b0;
        end else if (cur_state == DECODE) begin
            branch_ne <= (op == OP_BNE);
        end
    end

    assign taken = branch & (branch_ne ? ~zero : zero);
`else
    assign taken = branch & zero;
`endif

    always_comb begin
        op_ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
`ifdef MULTICYCLE_BNE_EN
        op_ok = op_ok || (op == OP_BNE);
`endif
        funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                   (funct == FN_OR) || (funct == FN_SLT);
    end

    // Next-state logic; unsupported opcodes and illegal encodings fall back to FETCH.
    always_comb begin
        nxt_state = FETCH;
        case (cur_state)
            FETCH:   nxt_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt_state = MEMADR;
                    OP_RTYPE:     nxt_state = EXECUTE;
                    OP_BEQ:       nxt_state = BRANCH;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       nxt_state = BRANCH;
`endif
                    OP_ADDI:      nxt_state = ADDIEX;
                    OP_J:         nxt_state = JUMP;
                    default:      nxt_state = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW) begin
                    nxt_state = MEMRD;
                end else if (op == OP_SW) begin
                    nxt_state = MEMWR;
                end else begin
                    nxt_state = FETCH;
                end
            end
            MEMRD:   nxt_state = MEMWB;
            EXECUTE: nxt_state = ALUWB;
            ADDIEX:  nxt_state = ADDIWB;
            default: nxt_state = FETCH;
        endcase
    end

    // Moore output decode; reset presents FETCH selects with every enable held low.
    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        alucontrol = 3'b010;
        bad_op     = 1'b0;
        pcen       = 1'b0;
        dec_state  = rst ? FETCH : cur_state;

        case (dec_state)
            FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            DECODE: begin
                alusrcb = 2'b11;
                bad_op  = !op_ok || ((op == OP_RTYPE) && !funct_ok);
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:  iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase

        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    FN_SUB:  alucontrol = 3'b110;
                    FN_AND:  alucontrol = 3'b000;
                    FN_OR:   alucontrol = 3'b001;
                    FN_SLT:  alucontrol = 3'b111;
                    default: alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase

        pcen = pcwrite | taken;

        if (rst) begin
            pcen     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            bad_op   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases then random instructions,
// compared each cycle against a table-driven instruction model.
module tb_multicycle_ctrl;

    typedef int seq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       bad_op;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .state(state), .bad_op(bad_op)
    );

    // States visited by one instruction, from the per-opcode cycle counts.
    task automatic seq_of(input logic [5:0] o, output seq_t q);
        q = {};
        q.push_back(0);
        q.push_back(1);
        case (o)
            6'b100011: begin q.push_back(2); q.push_back(3); q.push_back(4); end
            6'b101011: begin q.push_back(2); q.push_back(5); end
            6'b000000: begin q.push_back(6); q.push_back(7); end
            6'b000100: q.push_back(8);
`ifdef MULTICYCLE_BNE_EN
            6'b000101: q.push_back(8);
`endif
            6'b001000: begin q.push_back(9); q.push_back(10); end
            6'b000010: q.push_back(11);
            default: ;
        endcase
    endtask

    function automatic logic [19:0] model(int s, logic r, logic [5:0] o, logic [5:0] f, logic z);
        int d;
        logic pcw, br, io, mw, irw, rw, rd, mtr, asa, bad, ok, isbne, pe;
        logic [1:0] asb, pcs, aop;
        logic [2:0] ac;
        d = r ? 0 : s;
        {pcw, br, io, mw, irw, rw, rd, mtr, asa} = '0;
        asb = 2'b00; pcs = 2'b00; aop = 2'b00;
        case (d)
            0:  begin irw = 1; pcw = 1; asb = 2'b01; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  io = 1;
            4:  begin mtr = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (aop == 2'b01) ac = 3'b110;
        else if (aop == 2'b10) begin
            case (f)
                6'b100010: ac = 3'b110;
                6'b100100: ac = 3'b000;
                6'b100101: ac = 3'b001;
                6'b101010: ac = 3'b111;
                default:   ac = 3'b010;
            endcase
        end else ac = 3'b010;
        ok = o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        isbne = 1'b0;
`ifdef MULTICYCLE_BNE_EN
        ok = ok || (o == 6'b000101);
        isbne = (o == 6'b000101);
`endif
        bad = (d == 1) && (!ok || ((o == 6'b000000) &&
              !(f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})));
        pe = pcw | (br & (isbne ? ~z : z));
        if (r) begin pe = 0; mw = 0; irw = 0; rw = 0; bad = 0; end
        return {4'(s), pe, io, mw, irw, rw, rd, mtr, asa, asb, pcs, ac, bad};
    endfunction

    task automatic check(input string tag, input int s);
        logic [19:0] obs, exp;
        obs = {state, pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
               alusrcb, pcsrc, alucontrol, bad_op};
        exp = model(s, rst, op, funct, zero);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s st=%0d op=%b fn=%b z=%b rst=%b observed=%h expected=%h",
                   tag, s, op, funct, zero, rst, obs, exp);
        end
    endtask

    // zmode: 0/1 forces zero, 2 randomizes it; rst_at raises reset at that step (-1 = never).
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                             input int zmode, input int rst_at);
        seq_t q;
        seq_of(o, q);
        foreach (q[i]) begin
            @(negedge clk);
            if (i == 0) begin op = o; funct = f; end
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            if (i == rst_at) rst = 1'b1;
            #1 check(tag, q[i]);
            if (rst) begin
                @(negedge clk);
                #1 check({tag, "_rst"}, 0);
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        logic [5:0] ops[8];
        logic [5:0] fns[6];
        logic [5:0] o, f;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b001000, 6'b000010, 6'b000101, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

        rst = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 check("reset", 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        run_instr("lw",      6'b100011, 6'b000000, 2, -1);
        run_instr("slt",     6'b000000, 6'b101010, 2, -1);
        run_instr("beq_t",   6'b000100, 6'b000000, 1, -1);
        run_instr("beq_nt",  6'b000100, 6'b000000, 0, -1);
        run_instr("badop",   6'b111111, 6'b000000, 2, -1);
        run_instr("badfn",   6'b000000, 6'b111000, 2, -1);
        run_instr("sw_rst",  6'b101011, 6'b000000, 2, 3);
        run_instr("addi",    6'b001000, 6'b000000, 2, -1);
        run_instr("j",       6'b000010, 6'b000000, 2, -1);
        run_instr("bne_nz",  6'b000101, 6'b000000, 0, -1);
        run_instr("bne_z",   6'b000101, 6'b000000, 1, -1);

        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 7);
            o = (k == 7) ? 6'($urandom_range(0, 63)) : ops[k];
            f = fns[$urandom_range(0, 5)];
            if (f == 6'b000000) f = 6'($urandom_range(0, 63));
            run_instr("rand", o, f, 2, ($urandom_range(0, 19) == 0) ? 1 : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath that succeeds the single-cycle core.
- One shared instruction/data memory; each instruction takes 3-5 cycles (FETCH, DECODE, then per-op states).
- Drives every datapath mux select and write enable, plus the ALU control code. The datapath supplies opcode, funct and the ALU zero flag.
- Sits inside the mips wrapper, alongside the datapath.

Parameters:
- STATE_W, 4, width of the state register (12 states; encodings 0-11 in listed order).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- op  input  6  instr[31:26] from the instruction register.
- funct  input  6  instr[5:0] from the instruction register.
- zero  input  1  ALU zero flag, same cycle.
- pcen  output  1  PC register enable.
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- memwrite  output  1  memory write enable.
- irwrite  output  1  instruction register load.
- regwrite  output  1  register file write enable.
- regdst  output  1  write register select: 0=rt, 1=rd.
- memtoreg  output  1  write data select: 0=ALUOut, 1=MDR.
- alusrca  output  1  ALU A select: 0=PC, 1=rs.
- alusrcb  output  2  ALU B select: 00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2.
- pcsrc  output  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target.
- alucontrol  output  3  ALU operation code.
- state  output  STATE_W  current state, for debug/bench.
- bad_op  output  1  one-cycle pulse in DECODE on an unsupported opcode or funct.

Behaviour:
- Reset: synchronous on clk rising edge while rst=1; state<=FETCH.
- While rst=1, pcen, memwrite, irwrite, regwrite and bad_op are forced 0; other outputs follow FETCH decode.
- The first FETCH executes in the first cycle after rst falls.
- Outputs are Moore-decoded from state. The only exception is pcen = pcwrite | (branch & zero), which is combinational on zero.
- Unlisted outputs are 0 in every state.
- State outputs (aluop is internal, 2 bits):
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE on op:
    - 100011 (lw) or 101011 (sw) -> MEMADR.
    - 000000 (R-type) -> EXECUTE.
    - 000100 (beq) -> BRANCH.
    - 001000 (addi) -> ADDIEX.
    - 000010 (j) -> JUMP.
    - anything else -> FETCH, with bad_op=1.
  - MEMADR -> MEMRD if lw, MEMWR if sw. MEMRD->MEMWB.
  - EXECUTE->ALUWB. ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP all -> FETCH.
- Cycles per instruction: lw 5; sw, R-type, addi 4; beq, j 3.
- ALU decode:
  - aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
  - aluop 10 -> from funct: 100000 add 010; 100010 sub 110; 100100 and 000; 100101 or 001; 101010 slt 111; other -> 010.
  - Unsupported funct on R-type: bad_op pulses in DECODE and the FSM still executes the instruction as add (no trap).
- Illegal state encodings (12-15) -> FETCH on the next edge; all enables 0 while in them.
- rst asserted mid-instruction: abort at the next edge; no write enable is asserted in the reset cycle.

Optional Feature:
- Macro: MULTICYCLE_BNE_EN.
- Defined:
  - op 000101 (bne) decodes to BRANCH with an internal branch_ne flag latched in DECODE.
  - pcen = pcwrite | (branch & (branch_ne ? ~zero : zero)).
  - bne takes 3 cycles, like beq.
- Undefined: 000101 is unsupported (bad_op pulse, return to FETCH); no branch_ne logic.

Test Plan:
- rst=1 for 3 cycles with op=100011 -> state=0, pcen=irwrite=regwrite=memwrite=0 throughout. First post-reset cycle has state=FETCH, pcen=1, irwrite=1, alusrcb=01, alucontrol=010.
- op=100011 (lw) -> states 0,1,2,3,4,0. MEMRD has iord=1; MEMWB has regwrite=1, memtoreg=1, regdst=0.
- op=000000, funct=101010 (slt) -> EXECUTE has alucontrol=111, alusrca=1; ALUWB has regwrite=1, regdst=1; back in FETCH after 4 cycles.
- op=000100 (beq) with zero=1 -> pcen=1, pcsrc=01, alucontrol=110 in BRANCH. Repeat with zero=0 -> pcen=0.
- op=111111 -> bad_op=1 for exactly one cycle in DECODE, then FETCH; no regwrite or memwrite asserted.
- op=101011 (sw) with rst raised during MEMWR -> memwrite=0 in that cycle; state=FETCH after the edge. With MULTICYCLE_BNE_EN, op=000101 and zero=0 -> pcen=1 in BRANCH.
